// File: rtl/pmem_arbiter_pkg.sv
// Shared types and constants for the BIP program-memory arbiter.
// Owner encoding matches the requester that receives the next-cycle read data.
package bip_pmem_pkg;

    localparam int PMEM_ADDR_W = 11;
    localparam int PMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    // Round-robin last-winner pointer values
    localparam logic RR_FETCH = 1'b0;
    localparam logic RR_LOAD  = 1'b1;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bus bundle between fetch, loader, program memory and the arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface pmem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, m_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, m_addr, m_we, m_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, m_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, m_addr, m_we, m_wdata
    );

endinterface

// File: rtl/pmem_arbiter_pick.sv
// Combinational winner selection for the program-memory arbiter.
// PMEM_ARB_RR_EN selects round-robin; otherwise fixed priority with a fetch starvation guard.
module pmem_arb_pick
    import bip_pmem_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic              f_req_i,
    input  logic              l_req_i,
    input  logic              l_lock_i,
`ifdef PMEM_ARB_RR_EN
    input  logic              rr_last_i,
`else
    input  logic [WAIT_W-1:0] wait_cnt_i,
`endif
    output owner_e            win_o
);

    logic fetch_ok;

    always_comb begin
        win_o    = OWN_NONE;
        fetch_ok = f_req_i && !l_lock_i;
        if (fetch_ok && l_req_i) begin
`ifdef PMEM_ARB_RR_EN
            win_o = (rr_last_i == RR_LOAD) ? OWN_FETCH : OWN_LOAD;
`else
            // Fetch has been starved long enough: let it through once
            win_o = (wait_cnt_i == WAIT_W'(MAX_WAIT)) ? OWN_FETCH : OWN_LOAD;
`endif
        end else if (fetch_ok) begin
            win_o = OWN_FETCH;
        end else if (l_req_i) begin
            win_o = OWN_LOAD;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Program-memory arbiter: fetch (read-only) vs loader (read/write), one grant per cycle.
// Build option PMEM_ARB_RR_EN: round-robin instead of fixed priority with starvation guard.
module pmem_arbiter
    import bip_pmem_pkg::*;
#(
    parameter int ADDR_W   = PMEM_ADDR_W,
    parameter int DATA_W   = PMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    pmem_arbiter_if.slave  bus
);

    owner_e win;
    owner_e owner_q, owner_d;

`ifdef PMEM_ARB_RR_EN
    logic rr_q, rr_d;

    pmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (1)
    ) u_pick (
        .f_req_i   (bus.f_req),
        .l_req_i   (bus.l_req),
        .l_lock_i  (bus.l_lock),
        .rr_last_i (rr_q),
        .win_o     (win)
    );
`else
    localparam int WAIT_W = cnt_width(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;

    pmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_pick (
        .f_req_i    (bus.f_req),
        .l_req_i    (bus.l_req),
        .l_lock_i   (bus.l_lock),
        .wait_cnt_i (wait_q),
        .win_o      (win)
    );
`endif

    assign bus.f_gnt = (win == OWN_FETCH);
    assign bus.l_gnt = (win == OWN_LOAD);

    always_comb begin
        bus.m_addr  = '0;
        bus.m_we    = 1'b0;
        bus.m_wdata = '0;
        case (win)
            OWN_FETCH: bus.m_addr = bus.f_addr;
            OWN_LOAD: begin
                bus.m_addr  = bus.l_addr;
                bus.m_we    = bus.l_we;
                bus.m_wdata = bus.l_wdata;
            end
            default: ;
        endcase
    end

    // Only reads need an owner; writes and idle cycles return nothing
    always_comb begin
        owner_d = OWN_NONE;
        if (win == OWN_FETCH) begin
            owner_d = OWN_FETCH;
        end else if (win == OWN_LOAD && !bus.l_we) begin
            owner_d = OWN_LOAD;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign bus.f_rvalid = (owner_q == OWN_FETCH);
    assign bus.l_rvalid = (owner_q == OWN_LOAD);
    assign bus.f_rdata  = bus.m_rdata;
    assign bus.l_rdata  = bus.m_rdata;

`ifdef PMEM_ARB_RR_EN
    always_comb begin
        rr_d = rr_q;
        if (win == OWN_FETCH) begin
            rr_d = RR_FETCH;
        end else if (win == OWN_LOAD) begin
            rr_d = RR_LOAD;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= RR_LOAD;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Lock clears, a fetch grant clears, each denied fetch counts up to MAX_WAIT
    always_comb begin
        wait_d = wait_q;
        if (bus.l_lock || win == OWN_FETCH) begin
            wait_d = '0;
        end else if (bus.f_req && wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter; expected read data queued at grant, checked at rvalid.
// Contention expectations follow the PMEM_ARB_RR_EN build option.
module tb_pmem_arbiter;
    import bip_pmem_pkg::*;

    localparam int AW = 11;
    localparam int DW = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    pmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    pmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] lq[$];
    logic [DW-1:0] fexp, lexp;

    // Hand-written program image for the low addresses
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            11'd0:   return 16'h1801;
            11'd1:   return 16'h0800;
            11'd2:   return 16'h1002;
            11'd3:   return 16'h2803;
            11'd4:   return 16'h3004;
            11'd5:   return 16'h0805;
            11'd6:   return 16'h7006;
            11'd7:   return 16'h0007;
            default: return 16'h0000;
        endcase
    endfunction

    // Synchronous-read memory model, 1-cycle latency
    logic [DW-1:0] mem     [0:2**AW-1];
    logic          written [0:2**AW-1];
    always @(posedge clock) begin
        if (bus.m_we) begin
            mem[bus.m_addr]     <= bus.m_wdata;
            written[bus.m_addr] <= 1'b1;
        end
        bus.m_rdata <= (written[bus.m_addr] === 1'b1) ? mem[bus.m_addr] : init_val(bus.m_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: any pending expectation or asserted rvalid is compared
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (fq.size() > 0 || bus.f_rvalid) begin
                if (fq.size() == 0) begin
                    chk("f_rvalid_unexpected", 32'(bus.f_rvalid), 32'd0);
                end else begin
                    fexp = fq.pop_front();
                    chk("f_rvalid", 32'(bus.f_rvalid), 32'd1);
                    chk("f_rdata", 32'(bus.f_rdata), 32'(fexp));
                end
            end
            if (lq.size() > 0 || bus.l_rvalid) begin
                if (lq.size() == 0) begin
                    chk("l_rvalid_unexpected", 32'(bus.l_rvalid), 32'd0);
                end else begin
                    lexp = lq.pop_front();
                    chk("l_rvalid", 32'(bus.l_rvalid), 32'd1);
                    chk("l_rdata", 32'(bus.l_rdata), 32'(lexp));
                end
            end
        end
    end

    task automatic step(input logic ef, input logic el, input logic [DW-1:0] fd,
                        input logic [DW-1:0] ld, input string tag);
        @(negedge clock);
        chk({tag, "_f_gnt"}, 32'(bus.f_gnt), 32'(ef));
        chk({tag, "_l_gnt"}, 32'(bus.l_gnt), 32'(el));
        if (ef) fq.push_back(fd);
        if (el && !bus.l_we) lq.push_back(ld);
        @(posedge clock);
        #1;
    endtask

    logic ef_tab [6];
    logic el_tab [6];

    initial begin
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_lock = 1'b0;
`ifdef PMEM_ARB_RR_EN
        ef_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        el_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        ef_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        el_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
        repeat (2) @(posedge clock);
        #1;
        chk("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        chk("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        chk("rst_m_we", 32'(bus.m_we), 32'd0);
        chk("rst_owner", 32'(dut.owner_q), 32'(OWN_NONE));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Fetch only, back-to-back
        bus.f_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.f_addr = AW'(i);
            step(1'b1, 1'b0, init_val(AW'(i)), '0, "t1");
        end
        bus.f_req = 1'b0;
        step(1'b0, 1'b0, '0, '0, "t1_idle");

        // Reset while a fetch read is in flight
        bus.f_req = 1'b1; bus.f_addr = 11'd1;
        step(1'b1, 1'b0, init_val(11'd1), '0, "t5_pre");
        bus.f_addr = 11'd2;
        @(negedge clock);
        chk("t5_f_gnt", 32'(bus.f_gnt), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        fq.delete();
        lq.delete();
        chk("t5_f_rvalid_now", 32'(bus.f_rvalid), 32'd0);
        chk("t5_l_rvalid_now", 32'(bus.l_rvalid), 32'd0);
        chk("t5_owner", 32'(dut.owner_q), 32'(OWN_NONE));
        bus.f_req = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("t5_f_rvalid_rel", 32'(bus.f_rvalid), 32'd0);
        step(1'b0, 1'b0, '0, '0, "t5_idle");

        // Continuous contention straight after reset
        bus.f_req = 1'b1; bus.f_addr = 11'd5;
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 11'd3;
        for (int i = 0; i < 6; i++) begin
            step(ef_tab[i], el_tab[i], init_val(11'd5), init_val(11'd3), "t2");
        end
        bus.f_req = 1'b0; bus.l_req = 1'b0;

        // Lock: in-flight fetch completes, then fetch is blocked
        bus.f_req = 1'b1; bus.f_addr = 11'd6;
        step(1'b1, 1'b0, init_val(11'd6), '0, "t3_pre");
        bus.l_lock = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, '0, "t3_lock");
`ifndef PMEM_ARB_RR_EN
        chk("t3_wait_cnt", 32'(dut.wait_q), 32'd0);
`endif
        bus.l_lock = 1'b0;
        step(1'b1, 1'b0, init_val(11'd6), '0, "t3_release");
`ifndef PMEM_ARB_RR_EN
        // Long lock must not leave the starvation guard armed
        bus.l_lock = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, '0, "t3_lock2");
        bus.l_lock = 1'b0; bus.l_req = 1'b1; bus.l_addr = 11'd3;
        step(1'b0, 1'b1, '0, init_val(11'd3), "t3_cnt_clr");
        bus.l_req = 1'b0;
`endif
        bus.f_req = 1'b0;
        step(1'b0, 1'b0, '0, '0, "t3_idle");

        // Loader write then read-back of the same address
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 11'd7; bus.l_wdata = 16'hBEEF;
        #1;
        chk("t4_wr_m_we", 32'(bus.m_we), 32'd1);
        chk("t4_wr_m_addr", 32'(bus.m_addr), 32'd7);
        chk("t4_wr_m_wdata", 32'(bus.m_wdata), 32'hBEEF);
        step(1'b0, 1'b1, '0, '0, "t4_wr");
        bus.l_we = 1'b0;
        #1;
        chk("t4_rd_m_we", 32'(bus.m_we), 32'd0);
        step(1'b0, 1'b1, '0, 16'hBEEF, "t4_rd");
        bus.l_req = 1'b0; bus.l_wdata = '0;
        #1;
        chk("t4_idle_m_we", 32'(bus.m_we), 32'd0);
        chk("t4_idle_m_addr", 32'(bus.m_addr), 32'd0);
        chk("t4_idle_m_wdata", 32'(bus.m_wdata), 32'd0);
        step(1'b0, 1'b0, '0, '0, "t4_idle");
        step(1'b0, 1'b0, '0, '0, "drain");
        chk("queues_drained", 32'(fq.size() + lq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
